// File: rtl/vending_pkg.sv
// Shared types and constants for the vending FSM and its dispenser stage.
package vending_pkg;

    localparam int CHANGE_W         = 3;
    localparam int NICKEL_UNITS     = 1;
    localparam int DIME_UNITS       = 2;
    localparam int MAX_CHANGE_UNITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VEND,
        ST_COIN_ON,
        ST_COIN_OFF
    } disp_state_t;

    typedef struct packed {
        logic [1:0] dimes;
        logic       nickels;
    } coins_t;

    // Out-of-range change codes pay out nothing.
    function automatic coins_t split_change(input logic [CHANGE_W-1:0] change);
        coins_t c;
        c = '0;
        if (int'(change) <= MAX_CHANGE_UNITS) begin
            c.dimes   = 2'(int'(change) / DIME_UNITS);
            c.nickels = 1'((int'(change) % DIME_UNITS) / NICKEL_UNITS);
        end
        return c;
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; o_expire is high while the count sits at zero.
module pulse_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/vend_dispenser.sv
// Turns each vending sale into motor and coin-ejector pulses, with a one-deep pending slot.
// Optional VEND_DISPENSER_STATS_EN adds saturating sale and coin counters.
//
//   state       | meaning
//   ------------+----------------------------------------------
//   ST_IDLE     | waiting for a pending sale or a soda strobe
//   ST_VEND     | can-release motor on
//   ST_COIN_ON  | one ejector on (dimes first, then the nickel)
//   ST_COIN_OFF | ejectors off, gap after each coin
module vend_dispenser
    import vending_pkg::*;
#(
    parameter int VEND_CYCLES = 4,
    parameter int COIN_PULSE  = 2,
    parameter int COIN_GAP    = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_soda,
    input  logic [CHANGE_W-1:0] i_change,
    output logic                o_motor,
    output logic                o_dime_eject,
    output logic                o_nickel_eject,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_overrun,
    output logic                o_bad_change
`ifdef VEND_DISPENSER_STATS_EN
    ,
    output logic [15:0]         o_sales_cnt,
    output logic [15:0]         o_coins_cnt
`endif
);

    localparam int MAX_VC = (VEND_CYCLES > COIN_PULSE) ? VEND_CYCLES : COIN_PULSE;
    localparam int MAX_P  = (MAX_VC > COIN_GAP) ? MAX_VC : COIN_GAP;
    localparam int TW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    disp_state_t r_state, w_next;

    logic          w_load, w_expire, w_start, w_consume, w_coin_exit;
    logic [TW-1:0] w_load_val;
    logic          w_direct, w_queue, w_accept, w_done_set;
    coins_t        w_src, w_in_coins;

    logic       r_pend_valid;
    coins_t     r_pend;
    logic [1:0] r_dimes;
    logic       r_nickels;
    logic       r_motor, r_dime, r_nickel, r_busy, r_done, r_overrun, r_bad;

    pulse_timer #(.W(TW)) u_phase_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_consume   = 1'b0;
        w_coin_exit = 1'b0;
        w_load_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend_valid) begin
                    w_start   = 1'b1;
                    w_consume = 1'b1;
                end else if (i_soda) begin
                    w_start = 1'b1;
                end
                if (w_start) w_next = ST_VEND;
            end
            ST_VEND: begin
                if (w_expire) w_next = ((r_dimes != '0) || r_nickels) ? ST_COIN_ON : ST_IDLE;
            end
            ST_COIN_ON: begin
                if (w_expire) begin
                    w_next      = ST_COIN_OFF;
                    w_coin_exit = 1'b1;
                end
            end
            ST_COIN_OFF: begin
                // counters were already decremented when COIN_ON was left
                if (w_expire) w_next = ((r_dimes != '0) || r_nickels) ? ST_COIN_ON : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        case (w_next)
            ST_VEND:     w_load_val = TW'(VEND_CYCLES - 1);
            ST_COIN_ON:  w_load_val = TW'(COIN_PULSE - 1);
            ST_COIN_OFF: w_load_val = TW'(COIN_GAP - 1);
            default:     w_load_val = '0;
        endcase
    end

    assign w_load     = (w_next != r_state);
    assign w_in_coins = split_change(i_change);
    assign w_src      = w_consume ? r_pend : w_in_coins;
    assign w_direct   = i_soda && (r_state == ST_IDLE) && !r_pend_valid;
    assign w_queue    = i_soda && !w_direct;
    assign w_accept   = w_queue && (!r_pend_valid || w_consume);
    assign w_done_set = (r_state == ST_IDLE) && r_busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_valid <= 1'b0;
            r_pend       <= '0;
            r_dimes      <= '0;
            r_nickels    <= 1'b0;
            r_overrun    <= 1'b0;
            r_bad        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend       <= w_in_coins;
            end else if (w_consume) begin
                r_pend_valid <= 1'b0;
            end
            if (w_start) begin
                r_dimes   <= w_src.dimes;
                r_nickels <= w_src.nickels;
            end else if (w_coin_exit) begin
                if (r_dimes != '0) r_dimes   <= r_dimes - 1'b1;
                else               r_nickels <= 1'b0;
            end
            if (w_queue && !w_accept) r_overrun <= 1'b1;
            if (i_soda && (i_change > CHANGE_W'(MAX_CHANGE_UNITS))) r_bad <= 1'b1;
        end
    end

    // Outputs lag the state by one cycle so each is a pure flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_motor  <= 1'b0;
            r_dime   <= 1'b0;
            r_nickel <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_motor  <= (r_state == ST_VEND);
            r_dime   <= (r_state == ST_COIN_ON) && (r_dimes != '0);
            r_nickel <= (r_state == ST_COIN_ON) && (r_dimes == '0);
            r_busy   <= (r_state != ST_IDLE);
            r_done   <= w_done_set;
        end
    end

    assign o_motor        = r_motor;
    assign o_dime_eject   = r_dime;
    assign o_nickel_eject = r_nickel;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_overrun      = r_overrun;
    assign o_bad_change   = r_bad;

`ifdef VEND_DISPENSER_STATS_EN
    logic [15:0] r_sales_cnt, r_coins_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sales_cnt <= '0;
            r_coins_cnt <= '0;
        end else begin
            if (w_done_set && (r_sales_cnt != 16'hFFFF)) r_sales_cnt <= r_sales_cnt + 16'd1;
            if (w_coin_exit && (r_coins_cnt != 16'hFFFF)) r_coins_cnt <= r_coins_cnt + 16'd1;
        end
    end

    assign o_sales_cnt = r_sales_cnt;
    assign o_coins_cnt = r_coins_cnt;
`endif

endmodule
